// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared USB TX size encoding and buffer constants
package usb_pkg;

  typedef enum logic [1:0] {
    SIZE_1B = 2'd0,
    SIZE_2B = 2'd1,
    SIZE_4B = 2'd2
  } tx_size_e;

  localparam int BUF_DEPTH  = 64;
  localparam int BUF_ADDR_W = 6;

  // Byte count for a write size code; 0 marks the illegal encoding.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_1B: size_bytes = 3'd1;
      SIZE_2B: size_bytes = 3'd2;
      SIZE_4B: size_bytes = 3'd4;
      default: size_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/tx_buf_mem.sv
// rtl/tx_buf_mem.sv - byte register file with four write lanes and one async read port
module tx_buf_mem
  import usb_pkg::*;
#(
  parameter int DEPTH  = BUF_DEPTH,
  parameter int ADDR_W = BUF_ADDR_W
) (
  input  logic                   clk,
  input  logic [3:0]             wr_en,
  input  logic [3:0][ADDR_W-1:0] wr_idx,
  input  logic [3:0][7:0]        wr_data,
  input  logic [ADDR_W-1:0]      rd_idx,
  output logic [7:0]             rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (wr_en[k]) mem[wr_idx[k]] <= wr_data[k];
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/tx_data_buffer.sv
// rtl/tx_data_buffer.sv - byte FIFO feeding the USB TX path, 1/2/4-byte writes and single-byte pops
module tx_data_buffer
  import usb_pkg::*;
#(
  parameter int DEPTH  = BUF_DEPTH,
  parameter int ADDR_W = BUF_ADDR_W
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic              store_tx_data,
  input  logic [1:0]        tx_data_size,
  input  logic [31:0]       tx_data_in,
  input  logic              get_tx_data,
  output logic [7:0]        tx_packet_data,
  output logic [ADDR_W:0]   buff_occ,
  output logic              buffer_full,
  output logic              write_reject,
  output logic              underflow
);

  logic [ADDR_W:0]        wptr, rptr, occ;
  logic [2:0]             n_bytes;
  logic [ADDR_W+1:0]      need;
  logic                   wr_ok, pop_ok, empty;
  logic [3:0]             wr_en;
  logic [3:0][ADDR_W-1:0] wr_idx;
  logic [7:0]             rd_data;

  assign occ     = wptr - rptr;
  assign empty   = (occ == '0);
  assign n_bytes = size_bytes(tx_data_size);
  // Fit check uses occupancy before this cycle's pop.
  assign need    = (ADDR_W+2)'(occ) + (ADDR_W+2)'(n_bytes);
  assign wr_ok   = store_tx_data && !clear && (n_bytes != 3'd0)
                   && (need <= (ADDR_W+2)'(DEPTH));
  assign pop_ok  = get_tx_data && !clear && !empty;

  always_comb begin
    wr_en  = '0;
    wr_idx = '0;
    for (int k = 0; k < 4; k++) begin
      wr_idx[k] = wptr[ADDR_W-1:0] + ADDR_W'(k);
      wr_en[k]  = wr_ok && (3'(k) < n_bytes);
    end
  end

  tx_buf_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (tx_data_in),
    .rd_idx  (rptr[ADDR_W-1:0]),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr         <= '0;
      rptr         <= '0;
      write_reject <= 1'b0;
      underflow    <= 1'b0;
    end else if (clear) begin
      wptr         <= '0;
      rptr         <= '0;
      write_reject <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + (ADDR_W+1)'(n_bytes);
      if (pop_ok) rptr <= rptr + 1'b1;
      if (get_tx_data && empty) underflow <= 1'b1;
      write_reject <= store_tx_data && !wr_ok;
    end
  end

  assign buff_occ       = occ;
  assign buffer_full    = (occ == (ADDR_W+1)'(DEPTH));
  assign tx_packet_data = empty ? 8'h00 : rd_data;

endmodule

// File: doc/tx_data_buffer.md
Name: tx_data_buffer

Overview:
- Byte FIFO directly upstream of the USB TX path.
- Host-side register logic stores 1, 2 or 4 bytes per write.
- The TX FSM pops one byte per get_tx_data pulse.
- Outputs tx_packet_data and buff_occ feed tx_packet_data/buff_occ of the TX top; also flags rejected writes and empty-pops.

Parameters:
DEPTH, 64, number of byte entries (power of two)
ADDR_W, 6, log2(DEPTH); pointers are ADDR_W+1 bits with a wrap bit

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
clear  input  1  synchronous flush of all contents
store_tx_data  input  1  write strobe, one cycle per write
tx_data_size  input  2  0=1 byte, 1=2 bytes, 2=4 bytes, 3=illegal
tx_data_in  input  32  write data, byte0 = [7:0] sent first
get_tx_data  input  1  pop strobe from TX FSM
tx_packet_data  output  8  head byte (show-ahead)
buff_occ  output  ADDR_W+1  bytes currently stored, 0..DEPTH
buffer_full  output  1  buff_occ == DEPTH
write_reject  output  1  one-cycle pulse: write dropped
underflow  output  1  sticky: pop while empty

Behaviour:
- Reset (n_rst low, async):
  - Read and write pointers = 0, so buff_occ = 0.
  - buffer_full = 0, write_reject = 0, underflow = 0.
  - tx_packet_data = 8'h00.
  - Memory contents are don't-care.
- Storage: DEPTH x 8 register array.
  - wptr/rptr are ADDR_W+1 bits, with the low ADDR_W bits used as index.
  - buff_occ = wptr - rptr, modulo 2^(ADDR_W+1).
- Write (store_tx_data=1, size legal, clear=0):
  - N = 1/2/4. Write is accepted only if buff_occ + N <= DEPTH, using the occupancy before this cycle's pop.
  - Accepted: byte k of tx_data_in[8k+7:8k] goes to mem[(wptr+k) mod DEPTH] for k < N; wptr += N. Index wraps past DEPTH-1 to 0 inside a multi-byte write.
  - Not accepted, or size==3: nothing stored; write_reject = 1 on the next cycle, for exactly one cycle.
- Pop (get_tx_data=1, clear=0):
  - If buff_occ > 0: rptr += 1.
  - If buff_occ == 0: pointers unchanged and underflow is set. underflow clears only on clear or reset.
- tx_packet_data:
  - Combinational mem[rptr index] when buff_occ > 0, else 8'h00.
  - The byte is valid in the same cycle get_tx_data is asserted, and the pop takes effect at that edge.
  - Consumer latches the byte on the pop cycle.
- Simultaneous write and pop in one cycle:
  - Both take effect; buff_occ changes by N-1.
  - Fit check ignores the pop, so a full buffer plus a 1-byte write plus a pop is rejected.
- clear: has priority over write and pop in the same cycle.
  - Pointers = 0, underflow = 0.
  - No write_reject is generated for a write dropped by clear.
- Outputs buff_occ, buffer_full and underflow are all registered-state derived, with no combinational path from the inputs.
- write_reject is a registered pulse.
- No latency beyond a single cycle: a byte written at edge t is visible on tx_packet_data after edge t.

Decomposition:
- Shared package usb_pkg holds:
  - Size encoding enum: SIZE_1B=2'd0, SIZE_2B=2'd1, SIZE_4B=2'd2.
  - Constants BUF_DEPTH=64 and BUF_ADDR_W=6, which are also used by the TX FSM buff_occ comparison.
- One sub-module is natural: tx_buf_mem, a DEPTH x 8 register file.
  - Inputs: up to 4 write lanes with per-lane enable and index, plus one async read port.
  - Pointer, occupancy and flag logic stays in tx_data_buffer.

Test Plan:
- Reset, then 4-byte write 32'hDDCCBBAA -> buff_occ=4; four pops yield AA, BB, CC, DD in order; buff_occ=0, tx_packet_data=00.
- Fill with sixteen 4-byte writes -> buff_occ=64, buffer_full=1. A 1-byte write then gives a write_reject pulse and buff_occ stays 64.
- Wrap: write 62 bytes, pop 62, then write 4 bytes 32'h44332211 -> indices 62, 63, 0, 1 used; pops return 11, 22, 33, 44.
- Same cycle, buff_occ=10: 2-byte write plus pop -> buff_occ=11 and head advances by one. With buff_occ=63, a 2-byte write plus pop is rejected and buff_occ=62.
- Pop while empty -> underflow=1 and stays set, pointers unchanged. clear -> underflow=0, buff_occ=0. A write concurrent with clear is dropped with no reject.
- Assert n_rst low mid-stream at buff_occ=20 -> outputs go immediately to reset values, independent of clk. size=3 write -> reject pulse and no store.
